// File: rtl/mastermind_guess_sequencer.sv
// rtl/mastermind_guess_sequencer.sv - Mastermind game sequencer: cursor, guess entry, peg scoring, history
// Optional MM_FAST_SCORE_EN: single-cycle combinational scorer instead of the 21-cycle sequential one.

module mastermind_guess_sequencer #(
  parameter int NUM_SLOTS   = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
) (
  input  logic                             ClkPort,
  input  logic                             Reset,
  input  logic [NUM_SLOTS*COLOR_W-1:0]     correct_answer,
  input  logic [COLOR_W-1:0]               current_color,
  input  logic                             confirm_color,
  input  logic                             check_guess,
  input  logic                             btn_left,
  input  logic                             btn_right,
  input  logic [$clog2(MAX_GUESSES)-1:0]   hist_rd_idx,
  output logic [NUM_SLOTS*COLOR_W-1:0]     hist_rd_guess,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   hist_rd_black,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   hist_rd_white,
  output logic                             hist_rd_valid,
  output logic [NUM_SLOTS*COLOR_W-1:0]     current_guess,
  output logic [$clog2(NUM_SLOTS)-1:0]     cursor,
  output logic [$clog2(MAX_GUESSES)-1:0]   guess_num,
  output logic                             q_Start,
  output logic                             q_Input,
  output logic                             q_Check,
  output logic                             q_DoneC,
  output logic                             q_DoneNC
);

  localparam int GUESS_W   = NUM_SLOTS * COLOR_W;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int GN_W      = $clog2(MAX_GUESSES);
  localparam int SC_W      = $clog2(NUM_SLOTS + 1);
  localparam int LAST_STEP = NUM_SLOTS + NUM_SLOTS * NUM_SLOTS;
  localparam int CNT_W     = $clog2(LAST_STEP + 1);
  localparam int PAIR_W    = 2 * SLOT_W;

  // One-hot encoding so the state register bits are the state flag outputs.
  typedef enum logic [4:0] {
    ST_START   = 5'b00001,
    ST_INPUT   = 5'b00010,
    ST_CHECK   = 5'b00100,
    ST_DONE_C  = 5'b01000,
    ST_DONE_NC = 5'b10000
  } state_t;

  state_t                 state_q;
  logic [GUESS_W-1:0]     secret_q;
  logic [GUESS_W-1:0]     current_guess_q;
  logic [SLOT_W-1:0]      cursor_q;
  logic [GN_W-1:0]        guess_num_q;
  logic [GUESS_W-1:0]     hist_guess_q [MAX_GUESSES];
  logic [SC_W-1:0]        hist_black_q [MAX_GUESSES];
  logic [SC_W-1:0]        hist_white_q [MAX_GUESSES];
  logic [MAX_GUESSES-1:0] hist_valid_q;

  logic                   all_filled;
  logic                   score_done;
  logic [SC_W-1:0]        score_black;
  logic [SC_W-1:0]        score_white;

  always_comb begin
    all_filled = 1'b1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (current_guess_q[k*COLOR_W +: COLOR_W] == '0) all_filled = 1'b0;
    end
  end

`ifdef MM_FAST_SCORE_EN
  function automatic logic [2*SC_W-1:0] score_fn(input logic [GUESS_W-1:0] g,
                                                 input logic [GUESS_W-1:0] s);
    logic [NUM_SLOTS-1:0] gu;
    logic [NUM_SLOTS-1:0] su;
    logic [SC_W-1:0]      b;
    logic [SC_W-1:0]      w;
    gu = '0;
    su = '0;
    b  = '0;
    w  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (g[i*COLOR_W +: COLOR_W] == s[i*COLOR_W +: COLOR_W]) begin
        b     = b + SC_W'(1);
        gu[i] = 1'b1;
        su[i] = 1'b1;
      end
    end
    // Same (i outer, j inner) greedy order as the sequential scan.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (!gu[i] && !su[j] && g[i*COLOR_W +: COLOR_W] == s[j*COLOR_W +: COLOR_W]) begin
          w     = w + SC_W'(1);
          gu[i] = 1'b1;
          su[j] = 1'b1;
        end
      end
    end
    return {b, w};
  endfunction

  assign {score_black, score_white} = score_fn(current_guess_q, secret_q);
  assign score_done = 1'b1;
`else
  logic [CNT_W-1:0]     step_q;
  logic [SC_W-1:0]      black_q, black_d;
  logic [SC_W-1:0]      white_q, white_d;
  logic [NUM_SLOTS-1:0] gused_q, gused_d;
  logic [NUM_SLOTS-1:0] sused_q, sused_d;
  logic [PAIR_W-1:0]    pair_idx;
  logic [SLOT_W-1:0]    gi, sj;
  logic [COLOR_W-1:0]   g_col, s_col;
  logic                 in_phase_a;

  assign score_done  = (step_q == CNT_W'(LAST_STEP));
  assign score_black = black_q;
  assign score_white = white_q;

  // One comparator pair: steps 0..N-1 compare slot i to i, then N^2 steps walk (i,j).
  always_comb begin
    in_phase_a = (step_q < CNT_W'(NUM_SLOTS));
    pair_idx   = PAIR_W'(step_q - CNT_W'(NUM_SLOTS));
    if (in_phase_a) begin
      gi = step_q[SLOT_W-1:0];
      sj = step_q[SLOT_W-1:0];
    end else begin
      gi = pair_idx[PAIR_W-1:SLOT_W];
      sj = pair_idx[SLOT_W-1:0];
    end
    g_col   = current_guess_q[gi*COLOR_W +: COLOR_W];
    s_col   = secret_q[sj*COLOR_W +: COLOR_W];
    black_d = black_q;
    white_d = white_q;
    gused_d = gused_q;
    sused_d = sused_q;
    if (!score_done && g_col == s_col && !gused_q[gi] && !sused_q[sj]) begin
      if (in_phase_a) black_d = black_q + SC_W'(1);
      else            white_d = white_q + SC_W'(1);
      gused_d[gi] = 1'b1;
      sused_d[sj] = 1'b1;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      step_q  <= '0;
      black_q <= '0;
      white_q <= '0;
      gused_q <= '0;
      sused_q <= '0;
    end else if (state_q != ST_CHECK || score_done) begin
      step_q  <= '0;
      black_q <= '0;
      white_q <= '0;
      gused_q <= '0;
      sused_q <= '0;
    end else begin
      step_q  <= step_q + CNT_W'(1);
      black_q <= black_d;
      white_q <= white_d;
      gused_q <= gused_d;
      sused_q <= sused_d;
    end
  end
`endif

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q         <= ST_START;
      secret_q        <= '0;
      current_guess_q <= '0;
      cursor_q        <= '0;
      guess_num_q     <= '0;
      hist_valid_q    <= '0;
      for (int e = 0; e < MAX_GUESSES; e++) begin
        hist_guess_q[e] <= '0;
        hist_black_q[e] <= '0;
        hist_white_q[e] <= '0;
      end
    end else begin
      case (state_q)
        ST_START: begin
          if (confirm_color || check_guess) begin
            secret_q        <= correct_answer;
            current_guess_q <= '0;
            cursor_q        <= '0;
            state_q         <= ST_INPUT;
          end
        end
        ST_INPUT: begin
          if (confirm_color) begin
            if (current_color != '0) begin
              current_guess_q[cursor_q*COLOR_W +: COLOR_W] <= current_color;
              cursor_q <= cursor_q + 1'b1;
            end
          end else if (check_guess) begin
            if (all_filled) state_q <= ST_CHECK;
          end else if (btn_left != btn_right) begin
            cursor_q <= btn_left ? cursor_q - 1'b1 : cursor_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (score_done) begin
            hist_guess_q[guess_num_q] <= current_guess_q;
            hist_black_q[guess_num_q] <= score_black;
            hist_white_q[guess_num_q] <= score_white;
            hist_valid_q[guess_num_q] <= 1'b1;
            if (score_black == SC_W'(NUM_SLOTS)) begin
              state_q <= ST_DONE_C;
            end else if (guess_num_q == GN_W'(MAX_GUESSES - 1)) begin
              state_q <= ST_DONE_NC;
            end else begin
              guess_num_q     <= guess_num_q + GN_W'(1);
              current_guess_q <= '0;
              cursor_q        <= '0;
              state_q         <= ST_INPUT;
            end
          end
        end
        ST_DONE_C, ST_DONE_NC: begin
          if (check_guess) begin
            state_q      <= ST_START;
            guess_num_q  <= '0;
            hist_valid_q <= '0;
          end
        end
        default: state_q <= ST_START;
      endcase
    end
  end

  assign hist_rd_guess = hist_guess_q[hist_rd_idx];
  assign hist_rd_black = hist_black_q[hist_rd_idx];
  assign hist_rd_white = hist_white_q[hist_rd_idx];
  assign hist_rd_valid = hist_valid_q[hist_rd_idx];
  assign current_guess = current_guess_q;
  assign cursor        = cursor_q;
  assign guess_num     = guess_num_q;
  assign q_Start       = state_q[0];
  assign q_Input       = state_q[1];
  assign q_Check       = state_q[2];
  assign q_DoneC       = state_q[3];
  assign q_DoneNC      = state_q[4];

endmodule
